// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core: the master drives operands, the slave returns
// the registered result and flags.
interface alu_core_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0]   in1;
  logic signed [WIDTH-1:0]   in2;
  logic        [3:0]         op;
  logic                      invalid_data;
  logic signed [2*WIDTH-1:0] out;
  logic                      zero;
  logic                      error;

  modport master (
    output in1, in2, op, invalid_data,
    input  out, zero, error
  );

  modport slave (
    input  in1, in2, op, invalid_data,
    output out, zero, error
  );
endinterface

// File: rtl/alu_core.sv
// Single-cycle signed ALU with a registered 2*WIDTH result and error/zero flags.
// Optional feature: define ALU_REM_EN to enable signed remainder on op 8.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_core_if.slave  bus
);
  localparam int RW = 2 * WIDTH;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_REM = 4'd8
  } op_e;

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] b_safe;
  logic                 b_is_zero;
  logic signed [RW-1:0] out_d, out_q;
  logic                 error_d, error_q;
  logic                 zero_d, zero_q;

  assign a_ext     = {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1};
  assign b_ext     = {{WIDTH{bus.in2[WIDTH-1]}}, bus.in2};
  assign b_is_zero = (b_ext == '0);
  // Keeps the divider's inputs defined on the zero-divisor path; that result is discarded.
  assign b_safe    = b_is_zero ? {{(RW-1){1'b0}}, 1'b1} : b_ext;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    out_d   = '0;
    error_d = 1'b0;
    if (bus.invalid_data) begin
      error_d = 1'b1;
    end else begin
      case (bus.op)
        OP_ADD: out_d = a_ext + b_ext;
        OP_SUB: out_d = a_ext - b_ext;
        OP_MUL: out_d = a_ext * b_ext;
        OP_DIV: begin
          if (b_is_zero) error_d = 1'b1;
          else           out_d   = a_ext / b_safe;
        end
        OP_AND: out_d = a_ext & b_ext;
        OP_OR:  out_d = a_ext | b_ext;
        OP_XOR: out_d = a_ext ^ b_ext;
        OP_NOT: out_d = ~a_ext;
`ifdef ALU_REM_EN
        OP_REM: begin
          if (b_is_zero) error_d = 1'b1;
          else           out_d   = a_ext % b_safe;
        end
`endif
        default: error_d = 1'b1;
      endcase
    end
    zero_d = !error_d && (out_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignment so all of them update together at the edge.
    if (!rst_n) begin
      out_q   <= '0;
      error_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      error_q <= error_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.error = error_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed literal vectors plus a per-cycle
// comparison against an integer-arithmetic reference model.
module tb_alu_core;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   cmp_en;

  alu_core_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // Reference: plain 32-bit integer arithmetic, truncated to the 2*W result width.
  function automatic void model(input logic [3:0] op, input logic signed [W-1:0] x,
                                input logic signed [W-1:0] y, input logic inv,
                                output logic signed [2*W-1:0] r, output logic e);
    int a, b, t;
    a = x;
    b = y;
    t = 0;
    e = 1'b0;
    if (inv) e = 1'b1;
    else begin
      case (op)
        4'd0: t = a + b;
        4'd1: t = a - b;
        4'd2: t = a * b;
        4'd3: if (b == 0) e = 1'b1; else t = a / b;
        4'd4: t = a & b;
        4'd5: t = a | b;
        4'd6: t = a ^ b;
        4'd7: t = ~a;
`ifdef ALU_REM_EN
        4'd8: if (b == 0) e = 1'b1; else t = a % b;
`endif
        default: e = 1'b1;
      endcase
    end
    r = e ? '0 : t[2*W-1:0];
  endfunction

  logic signed [2*W-1:0] exp_out;
  logic                  exp_err;
  logic                  exp_zero;

  always @(posedge clk or negedge rst_n) begin
    logic signed [2*W-1:0] r;
    logic                  e;
    if (!rst_n) begin
      exp_out  <= '0;
      exp_err  <= 1'b0;
      exp_zero <= 1'b0;
    end else begin
      model(bus.op, bus.in1, bus.in2, bus.invalid_data, r, e);
      exp_out  <= r;
      exp_err  <= e;
      exp_zero <= !e && (r == '0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_out",   bus.out,   exp_out);
      check("model_error", bus.error, exp_err);
      check("model_zero",  bus.zero,  exp_zero);
    end
  end

  task automatic drive(input logic [3:0] op, input int a, input int b, input logic inv);
    bus.op           = op;
    bus.in1          = a[W-1:0];
    bus.in2          = b[W-1:0];
    bus.invalid_data = inv;
  endtask

  task automatic apply(input string name, input logic [3:0] op, input int a, input int b,
                       input logic inv, input int e_out, input logic e_err, input logic e_zero);
    @(negedge clk);
    drive(op, a, b, inv);
    @(posedge clk);
    #1;
    check({name, "_out"},   bus.out,   e_out);
    check({name, "_error"}, bus.error, e_err);
    check({name, "_zero"},  bus.zero,  e_zero);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    drive(4'd0, 0, 0, 1'b0);
    #1;
    check("reset_out",   bus.out,   0);
    check("reset_error", bus.error, 0);
    check("reset_zero",  bus.zero,  0);
    cmp_en = 1'b1;
    #11 rst_n = 1'b1;

    apply("add_100_100",    4'd0,  100,  100, 1'b0,   200, 1'b0, 1'b0);
    apply("sub_m128_1",     4'd1, -128,    1, 1'b0,  -129, 1'b0, 1'b0);
    apply("mul_m128_m128",  4'd2, -128, -128, 1'b0, 16384, 1'b0, 1'b0);
    apply("mul_5_0",        4'd2,    5,    0, 1'b0,     0, 1'b0, 1'b1);
    apply("div_m7_2",       4'd3,   -7,    2, 1'b0,    -3, 1'b0, 1'b0);
    apply("div_9_0",        4'd3,    9,    0, 1'b0,     0, 1'b1, 1'b0);
    apply("div_m128_m1",    4'd3, -128,   -1, 1'b0,   128, 1'b0, 1'b0);
    apply("div_invalid",    4'd3,   10,    2, 1'b1,     0, 1'b1, 1'b0);
    apply("op15",           4'd15,   3,    4, 1'b0,     0, 1'b1, 1'b0);
    apply("and_m1_5",       4'd4,   -1,    5, 1'b0,     5, 1'b0, 1'b0);
    apply("or_m128_1",      4'd5, -128,    1, 1'b0,  -127, 1'b0, 1'b0);
    apply("xor_m1_1",       4'd6,   -1,    1, 1'b0,    -2, 1'b0, 1'b0);
    apply("not_0",          4'd7,    0,   55, 1'b0,    -1, 1'b0, 1'b0);
    apply("xor_self_zero",  4'd6,   42,   42, 1'b0,     0, 1'b0, 1'b1);
`ifdef ALU_REM_EN
    apply("rem_m7_2",       4'd8,   -7,    2, 1'b0,    -1, 1'b0, 1'b0);
    apply("rem_7_m2",       4'd8,    7,   -2, 1'b0,     1, 1'b0, 1'b0);
    apply("rem_9_0",        4'd8,    9,    0, 1'b0,     0, 1'b1, 1'b0);
`else
    apply("op8_undefined",  4'd8,   -7,    2, 1'b0,     0, 1'b1, 1'b0);
`endif

    // Mid-cycle reset must clear a live non-zero result without a clock edge.
    apply("pre_rst_add",    4'd0,  100,  100, 1'b0,   200, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out",   bus.out,   0);
    check("midrst_error", bus.error, 0);
    check("midrst_zero",  bus.zero,  0);
    @(negedge clk);
    drive(4'd1, 20, 5, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_first_out", bus.out, 15);

    // Mid-cycle reset must also clear a live error flag.
    apply("pre_rst_err",    4'd15,   1,    1, 1'b0,     0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_err_error", bus.error, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back random traffic; the compare process checks every cycle.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the result width SHALL be 2*WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock; all outputs SHALL be registered on it.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in1  input  WIDTH  signed two's-complement operand A.
REQ-006 in2  input  WIDTH  signed two's-complement operand B.
REQ-007 op  input  4  operation select.
REQ-008 invalid_data  input  1  high marks operands as unusable for this cycle.
REQ-009 out  output  2*WIDTH  signed registered result.
REQ-010 zero  output  1  registered flag: result equals zero and no error.
REQ-011 error  output  1  registered flag: operation not performed.

Function
REQ-012 Latency: inputs sampled at rising edge N SHALL appear on out/zero/error after edge N; no handshake; a new operation SHALL be accepted every cycle.
REQ-013 Operands SHALL be sign-extended to 2*WIDTH before every operation.
REQ-014 op 0: out SHALL equal in1 + in2 (sign-extended, no overflow possible).
REQ-015 op 1: out SHALL equal in1 - in2.
REQ-016 op 2: out SHALL equal the full signed product in1 * in2.
REQ-017 op 3: out SHALL equal the signed quotient in1 / in2, truncated toward zero; -2^(WIDTH-1) / -1 SHALL give +2^(WIDTH-1) without error.
REQ-018 op 4: bitwise AND; op 5: bitwise OR; op 6: bitwise XOR; op 7: bitwise NOT of in1 — all on the sign-extended operands.
REQ-019 op 3 with in2 = 0 SHALL set error = 1 and out = 0.
REQ-020 Any op value with no defined operation SHALL set error = 1 and out = 0.
REQ-021 invalid_data = 1 SHALL set error = 1 and out = 0 for every op; this has priority over all other conditions.
REQ-022 zero SHALL be 1 only when error = 0 and out = 0; when error = 1, zero SHALL be 0.
REQ-023 error SHALL be 0 for every defined, valid, non-faulting operation.

Reset
REQ-024 While rst_n = 0: out = 0, zero = 0, error = 0, asynchronously and independent of clk.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-026 The first result after deassertion SHALL come from inputs sampled at the first rising edge with rst_n = 1.

Configuration
REQ-027 Macro ALU_REM_EN defined: op 8 SHALL give the signed remainder in1 % in2, with sign equal to the sign of in1; in2 = 0 SHALL give error = 1 and out = 0.
REQ-028 Macro ALU_REM_EN undefined: op 8 SHALL be an undefined operation per REQ-020; all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset with rst_n = 0 mid-cycle -> out = 0, zero = 0, error = 0 immediately, without waiting for a clock edge.
REQ-030 Arithmetic at WIDTH = 8:
- op 0, in1 = 100, in2 = 100 -> out = 200, error = 0.
- op 1, in1 = -128, in2 = 1 -> out = -129.
REQ-031 Multiply at WIDTH = 8:
- op 2, in1 = -128, in2 = -128 -> out = 16384.
- op 2, in1 = 5, in2 = 0 -> out = 0, zero = 1.
REQ-032 Divide at WIDTH = 8:
- op 3, in1 = -7, in2 = 2 -> out = -3.
- op 3, in1 = 9, in2 = 0 -> error = 1, out = 0, zero = 0.
REQ-033 Invalid data and undefined ops:
- op 3, invalid_data = 1, in1 = 10, in2 = 2 -> error = 1, out = 0.
- op 15 (and op 8 without ALU_REM_EN) -> error = 1.
REQ-034 Back-to-back ops on consecutive edges -> each result appears exactly one cycle after its inputs; check against a reference model over 1000 random vectors, including random op and invalid_data.
